// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch flush and interrupt injection sequencer.
// Outputs are combinational from the current inputs and the registered FSM state.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] id_ra,
  input  logic [1:0] id_rb,
  input  logic       id_uses_ra,
  input  logic       id_uses_rb,
  input  logic       ex_MemRead,
  input  logic [1:0] ex_dest,
  input  logic       ex_branch_taken,
  input  logic       intr_req,
  input  logic       reti_done,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       inject_bubble,
  output logic       int_inject,
  output logic       int_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    INJECT = 2'd2,
    MASKED = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lu;

  assign lu = ex_MemRead &&
              ((id_uses_ra && (id_ra == ex_dest)) || (id_uses_rb && (id_rb == ex_dest)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (intr_req) begin
          state_d = DRAIN;
          cnt_d   = 2'd2;
        end
      end
      DRAIN: begin
        // A taken branch refills the pipe with fresh fetches, so the drain restarts.
        if (ex_branch_taken) begin
          cnt_d = 2'd2;
        end else if (!lu) begin
          if (cnt_q <= 2'd1) begin
            state_d = INJECT;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      INJECT: begin
        if (!ex_branch_taken && !lu) state_d = MASKED;
      end
      MASKED: begin
        if (reti_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    inject_bubble = 1'b0;
    int_inject    = 1'b0;
    int_busy      = (state_q != IDLE);
    if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      inject_bubble = 1'b1;
    end else begin
      case (state_q)
        DRAIN: begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
        end
        INJECT: begin
          pc_stall   = 1'b1;
          int_inject = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table in IDLE plus interrupt FSM sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] id_ra, id_rb, ex_dest;
  logic       id_uses_ra, id_uses_rb, ex_MemRead, ex_branch_taken, intr_req, reti_done;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush, inject_bubble, int_inject, int_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .ex_MemRead(ex_MemRead), .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
    .intr_req(intr_req), .reti_done(reti_done),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .inject_bubble(inject_bubble),
    .int_inject(int_inject), .int_busy(int_busy)
  );

  // Expected-output bit order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, inject_bubble, int_inject, int_busy}
  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_LU     = 7'b1100100;
  localparam logic [6:0] O_BR     = 7'b0011000;
  localparam logic [6:0] O_DRAIN  = 7'b1010001;
  localparam logic [6:0] O_INJ    = 7'b1000011;
  localparam logic [6:0] O_MASK   = 7'b0000001;
  localparam logic [6:0] O_BRBUSY = 7'b0011001;
  localparam logic [6:0] O_LUBUSY = 7'b1100101;

  typedef struct {
    string      name;
    logic [1:0] ra, rb, dest;
    logic       ura, urb, mr, br, reti;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [1:0] ra, logic [1:0] rb, logic ura, logic urb,
                              logic mr, logic [1:0] dest, logic br, logic reti, logic [6:0] exp);
    vec_t v;
    v.name = n; v.ra = ra; v.rb = rb; v.ura = ura; v.urb = urb;
    v.mr = mr; v.dest = dest; v.br = br; v.reti = reti; v.exp = exp;
    return v;
  endfunction

  task automatic chk(string name, logic [6:0] exp);
    logic [6:0] act;
    act = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, inject_bubble, int_inject, int_busy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
    if (id_ex_flush && inject_bubble) begin
      errors++;
      $display("FAIL %s: id_ex_flush and inject_bubble both high", name);
    end
  endtask

  // One cycle of the FSM sequences; lu=1 sets up an rb-side load-use match on r2.
  task automatic cyc(string name, logic intr, logic reti, logic br, logic lu, logic rst_v,
                     logic [6:0] exp);
    @(negedge clk);
    rst = rst_v; intr_req = intr; reti_done = reti; ex_branch_taken = br;
    id_ra = 2'd0; id_uses_ra = 1'b0;
    id_rb = 2'd2; id_uses_rb = lu; ex_MemRead = lu; ex_dest = 2'd2;
    #1;
    chk(name, exp);
  endtask

  initial begin
    vecs.push_back(mk("idle_zero",      0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
    vecs.push_back(mk("lu_rb",          0, 2, 0, 1, 1, 2, 0, 0, O_LU));
    vecs.push_back(mk("lu_one_cycle",   0, 2, 0, 1, 0, 2, 0, 0, O_NONE));
    vecs.push_back(mk("lu_ra",          1, 0, 1, 0, 1, 1, 0, 0, O_LU));
    vecs.push_back(mk("lu_ra_unused",   3, 0, 0, 0, 1, 3, 0, 0, O_NONE));
    vecs.push_back(mk("lu_rb_unused",   0, 1, 1, 0, 1, 1, 0, 0, O_NONE));
    vecs.push_back(mk("no_memread",     2, 2, 1, 1, 0, 2, 0, 0, O_NONE));
    vecs.push_back(mk("dest_mismatch",  1, 3, 1, 1, 1, 2, 0, 0, O_NONE));
    vecs.push_back(mk("lu_both",        3, 3, 1, 1, 1, 3, 0, 0, O_LU));
    vecs.push_back(mk("branch_over_lu", 0, 2, 0, 1, 1, 2, 1, 0, O_BR));
    vecs.push_back(mk("branch_only",    0, 0, 0, 0, 0, 0, 1, 0, O_BR));
    vecs.push_back(mk("reti_in_idle",   0, 0, 0, 0, 0, 0, 0, 1, O_NONE));
    vecs.push_back(mk("idle_after_reti",0, 0, 0, 0, 0, 0, 0, 0, O_NONE));

    rst = 1'b1; intr_req = 1'b0; reti_done = 1'b0; ex_branch_taken = 1'b0;
    id_ra = 2'd0; id_rb = 2'd0; id_uses_ra = 1'b0; id_uses_rb = 1'b0;
    ex_MemRead = 1'b0; ex_dest = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", O_NONE);

    foreach (vecs[i]) begin
      @(negedge clk);
      id_ra = vecs[i].ra; id_rb = vecs[i].rb; id_uses_ra = vecs[i].ura; id_uses_rb = vecs[i].urb;
      ex_MemRead = vecs[i].mr; ex_dest = vecs[i].dest;
      ex_branch_taken = vecs[i].br; reti_done = vecs[i].reti; intr_req = 1'b0;
      #1;
      chk(vecs[i].name, vecs[i].exp);
    end

    // Basic interrupt: one-cycle request, two drain cycles, inject, masked until reti.
    cyc("a_req",     1, 0, 0, 0, 0, O_NONE);
    cyc("a_drain1",  0, 0, 0, 0, 0, O_DRAIN);
    cyc("a_drain2",  0, 0, 0, 0, 0, O_DRAIN);
    cyc("a_inject",  0, 0, 0, 0, 0, O_INJ);
    cyc("a_masked1", 0, 0, 0, 0, 0, O_MASK);
    cyc("a_masked2", 0, 0, 0, 0, 0, O_MASK);
    cyc("a_reti",    0, 1, 0, 0, 0, O_MASK);
    cyc("a_idle",    0, 0, 0, 0, 0, O_NONE);
    cyc("a_idle2",   0, 0, 0, 0, 0, O_NONE);

    // Branch on the first drain cycle reloads the counter; inject lands 3 cycles later.
    cyc("b_req",     1, 0, 0, 0, 0, O_NONE);
    cyc("b_drain_br",0, 0, 1, 0, 0, O_BRBUSY);
    cyc("b_drain1",  0, 0, 0, 0, 0, O_DRAIN);
    cyc("b_drain2",  0, 0, 0, 0, 0, O_DRAIN);
    cyc("b_inject",  0, 0, 0, 0, 0, O_INJ);
    cyc("b_masked",  0, 0, 0, 0, 0, O_MASK);
    cyc("b_reti",    0, 1, 0, 0, 0, O_MASK);
    cyc("b_idle",    0, 0, 0, 0, 0, O_NONE);

    // Load-use holds the drain counter; branch and load-use both defer the inject.
    cyc("c_req",      1, 0, 0, 0, 0, O_NONE);
    cyc("c_drain_lu", 0, 0, 0, 1, 0, O_LUBUSY);
    cyc("c_drain1",   0, 0, 0, 0, 0, O_DRAIN);
    cyc("c_drain2",   0, 0, 0, 0, 0, O_DRAIN);
    cyc("c_inj_br",   0, 0, 1, 0, 0, O_BRBUSY);
    cyc("c_inj_lu",   0, 0, 0, 1, 0, O_LUBUSY);
    cyc("c_inject",   0, 0, 0, 0, 0, O_INJ);
    for (int k = 0; k < 10; k++) cyc("c_masked_intr", 1, 0, 0, 0, 0, O_MASK);
    cyc("c_reti_intr",  1, 1, 0, 0, 0, O_MASK);
    cyc("c_idle_intr",  1, 0, 0, 0, 0, O_NONE);
    cyc("c_redrain1",   1, 0, 0, 0, 0, O_DRAIN);

    // Reset while injecting returns to IDLE; held request restarts the drain.
    cyc("d_redrain2",   1, 0, 0, 0, 0, O_DRAIN);
    cyc("d_inject_rst", 1, 0, 0, 0, 1, O_INJ);
    cyc("d_after_rst",  1, 0, 0, 0, 0, O_NONE);
    cyc("d_restart",    1, 0, 0, 0, 0, O_DRAIN);
    cyc("d_final_rst",  0, 0, 0, 0, 1, O_DRAIN);
    cyc("d_idle_end",   0, 0, 0, 0, 0, O_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
